// File: rtl/alu_rs_pkg.sv
// -----------------------------------------------------------------------------
// alu_rs_pkg
// Shared definitions for the ALU reservation station.
//   - Legacy operaType macros: ENTRY_RANGE (ROB tag range), RS_SIZE, RS_IDX_W
//     and the ALU/branch opcode macros. They are guarded so an existing
//     operaType header takes precedence.
//   - Package: tag type, opcode constants and the CDB tag-match helper.
// Optional feature macro used by alu_rs: RS_AGE_SELECT_EN (oldest-first select).
// -----------------------------------------------------------------------------
`ifndef ALU_RS_PKG_SV
`define ALU_RS_PKG_SV

`ifndef ENTRY_RANGE
`define ENTRY_RANGE 4:0
`endif
`ifndef RS_SIZE
`define RS_SIZE 16
`endif
`ifndef RS_IDX_W
`define RS_IDX_W 4
`endif

`ifndef ADD
`define ADD  6'd1
`define SUB  6'd2
`define AND  6'd3
`define OR   6'd4
`define XOR  6'd5
`define SLL  6'd6
`define SRL  6'd7
`define BEQ  6'd8
`define BNE  6'd9
`endif

package alu_rs_pkg;

  // ROB entry tag carried on the CDB and stored per station entry.
  typedef logic [`ENTRY_RANGE] tag_t;
  localparam int ENTRY_W = $bits(tag_t);

  localparam logic [5:0] OP_ADD = `ADD;
  localparam logic [5:0] OP_SUB = `SUB;
  localparam logic [5:0] OP_AND = `AND;
  localparam logic [5:0] OP_OR  = `OR;
  localparam logic [5:0] OP_XOR = `XOR;
  localparam logic [5:0] OP_SLL = `SLL;
  localparam logic [5:0] OP_SRL = `SRL;
  localparam logic [5:0] OP_BEQ = `BEQ;
  localparam logic [5:0] OP_BNE = `BNE;

  // A pending operand is satisfied by a valid broadcast carrying its tag.
  function automatic logic tag_hit(input logic pending, input logic bcast,
                                   input tag_t q, input tag_t tag);
    return pending && bcast && (q == tag);
  endfunction

endpackage

`endif

// File: rtl/alu_rs_select.sv
// -----------------------------------------------------------------------------
// rs_select
// Picks one requesting entry and returns it as one-hot grant, binary index and
// valid. With AGE_EN=1 the oldest requester wins according to an order matrix;
// with AGE_EN=0 the lowest-index requester wins and the matrix is ignored.
// Ports:
//   i_req   [N]    request vector (ready entries or free slots)
//   i_age   [N*N]  order matrix, row-major: bit i*N+j set => entry i older than j
//   o_grant [N]    one-hot grant (all zero when no request)
//   o_idx   [IDX_W] index of the granted entry
//   o_vld          at least one request present
// -----------------------------------------------------------------------------
module rs_select #(
  parameter int N      = 16,
  parameter int IDX_W  = 4,
  parameter bit AGE_EN = 1'b0
) (
  input  logic [N-1:0]     i_req,
  input  logic [N*N-1:0]   i_age,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  generate
    if (AGE_EN) begin : g_age
      // Entry i wins when it is older than every other requester. Requesters
      // are always busy entries, whose mutual order is fully defined.
      always_comb begin
        o_grant = i_req;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            if ((j != i) && i_req[j] && !i_age[i*N+j]) begin
              o_grant[i] = 1'b0;
            end
          end
        end
      end
    end else begin : g_low
      logic w_unused_age;
      assign w_unused_age = ^i_age;
      // Isolate the lowest set bit.
      assign o_grant = i_req & (~i_req + {{(N-1){1'b0}}, 1'b1});
    end
  endgenerate

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (o_grant[i]) begin
        o_idx = o_idx | IDX_W'(i);
      end
    end
  end

  assign o_vld = |i_req;

endmodule

// File: rtl/alu_rs.sv
// -----------------------------------------------------------------------------
// alu_rs
// Reservation station in front of the ALU. Holds issued ALU/branch ops until
// both operands are available, snoops the two CDB ports (ALU, LSB) for wakeup,
// and dispatches one ready entry per cycle to the ALU through registered
// op/instruction/vj/vk/pc/imm/entry fields plus a one-cycle new_calculate.
// Optional feature: define RS_AGE_SELECT_EN to dispatch the oldest ready entry
// (order matrix); otherwise the lowest-index ready entry is dispatched.
// Ports:
//   clk_in, rst_n_in (async, active-low), rdy_in (global stall when low),
//   clear_in (misprediction flush, honored even when stalled)
//   issue_* : instruction written into the lowest free slot when !rs_full
//   rs_full : combinational, all entries busy
//   alu_broadcast/alu_result/alu_entry : CDB port 0 (priority)
//   lsb_broadcast/lsb_result/lsb_entry : CDB port 1
//   new_calculate, op, instruction, vj, vk, pc, imm, entry : dispatch outputs
// -----------------------------------------------------------------------------
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = `RS_SIZE,
  parameter int IDX_W   = `RS_IDX_W
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  input  logic                clear_in,

  input  logic                issue_valid,
  input  logic [5:0]          issue_op,
  input  logic [31:0]         issue_instruction,
  input  logic [31:0]         issue_pc,
  input  logic [31:0]         issue_imm,
  input  logic [31:0]         issue_vj,
  input  logic [31:0]         issue_vk,
  input  logic                issue_qj_busy,
  input  logic                issue_qk_busy,
  input  logic [`ENTRY_RANGE] issue_qj,
  input  logic [`ENTRY_RANGE] issue_qk,
  input  logic [`ENTRY_RANGE] issue_entry,
  output logic                rs_full,

  input  logic                alu_broadcast,
  input  logic [31:0]         alu_result,
  input  logic [`ENTRY_RANGE] alu_entry,
  input  logic                lsb_broadcast,
  input  logic [31:0]         lsb_result,
  input  logic [`ENTRY_RANGE] lsb_entry,

  output logic                new_calculate,
  output logic [5:0]          op,
  output logic [31:0]         instruction,
  output logic [31:0]         vj,
  output logic [31:0]         vk,
  output logic [31:0]         pc,
  output logic [31:0]         imm,
  output logic [`ENTRY_RANGE] entry
);

  // Per-entry control state (reset)
  logic [RS_SIZE-1:0] r_busy;
  logic [RS_SIZE-1:0] r_qj_busy;
  logic [RS_SIZE-1:0] r_qk_busy;

  // Per-entry payload (no reset: only read while the entry is busy)
  logic [5:0]  r_op   [RS_SIZE];
  logic [31:0] r_inst [RS_SIZE];
  logic [31:0] r_pc   [RS_SIZE];
  logic [31:0] r_imm  [RS_SIZE];
  logic [31:0] r_vj   [RS_SIZE];
  logic [31:0] r_vk   [RS_SIZE];
  tag_t        r_qj   [RS_SIZE];
  tag_t        r_qk   [RS_SIZE];
  tag_t        r_dest [RS_SIZE];

  // Dispatch output registers
  logic        r_new_calc;
  logic [5:0]  r_out_op;
  logic [31:0] r_out_inst;
  logic [31:0] r_out_vj;
  logic [31:0] r_out_vk;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_imm;
  tag_t        r_out_entry;

  logic [RS_SIZE-1:0] w_ready;
  logic [RS_SIZE-1:0] w_j_alu, w_j_lsb, w_k_alu, w_k_lsb;
  logic [RS_SIZE-1:0] w_free_grant, w_disp_grant;
  logic [IDX_W-1:0]   w_unused_free_idx, w_disp_idx;
  logic               w_free_vld, w_disp_vld;
  logic               w_issue_go;
  logic [RS_SIZE*RS_SIZE-1:0] w_age_flat;

  logic        w_iss_qj_busy, w_iss_qk_busy;
  logic [31:0] w_iss_vj, w_iss_vk;

  assign rs_full    = &r_busy;
  assign w_issue_go = issue_valid && w_free_vld;

  // Readiness and wakeup look only at registered state, so a wakeup at an
  // edge can dispatch at the following edge at the earliest.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_ready[i] = r_busy[i] && !r_qj_busy[i] && !r_qk_busy[i];
      w_j_alu[i] = r_busy[i] && tag_hit(r_qj_busy[i], alu_broadcast, r_qj[i], alu_entry);
      w_j_lsb[i] = r_busy[i] && tag_hit(r_qj_busy[i], lsb_broadcast, r_qj[i], lsb_entry);
      w_k_alu[i] = r_busy[i] && tag_hit(r_qk_busy[i], alu_broadcast, r_qk[i], alu_entry);
      w_k_lsb[i] = r_busy[i] && tag_hit(r_qk_busy[i], lsb_broadcast, r_qk[i], lsb_entry);
    end
  end

  // Issue bypass: an operand whose producer broadcasts in the issue cycle is
  // stored as a value; port 0 wins if both ports match.
  always_comb begin
    w_iss_vj      = issue_vj;
    w_iss_qj_busy = issue_qj_busy;
    if (tag_hit(issue_qj_busy, alu_broadcast, issue_qj, alu_entry)) begin
      w_iss_vj      = alu_result;
      w_iss_qj_busy = 1'b0;
    end else if (tag_hit(issue_qj_busy, lsb_broadcast, issue_qj, lsb_entry)) begin
      w_iss_vj      = lsb_result;
      w_iss_qj_busy = 1'b0;
    end
    w_iss_vk      = issue_vk;
    w_iss_qk_busy = issue_qk_busy;
    if (tag_hit(issue_qk_busy, alu_broadcast, issue_qk, alu_entry)) begin
      w_iss_vk      = alu_result;
      w_iss_qk_busy = 1'b0;
    end else if (tag_hit(issue_qk_busy, lsb_broadcast, issue_qk, lsb_entry)) begin
      w_iss_vk      = lsb_result;
      w_iss_qk_busy = 1'b0;
    end
  end

`ifdef RS_AGE_SELECT_EN
  localparam bit AGE_EN = 1'b1;

  // r_age[i][j] set => entry i was issued before entry j.
  logic [RS_SIZE-1:0] r_age [RS_SIZE];

  always_comb begin
    w_age_flat = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_age_flat[i*RS_SIZE +: RS_SIZE] = r_age[i];
    end
  end

  // A newly issued entry is younger than everything: its row is cleared and
  // its column set in every other row. Rows of free slots are stale but are
  // rewritten before they can ever be consulted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_age[i] <= '0;
      end
    end else if (rdy_in && !clear_in && w_issue_go) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_free_grant[i]) begin
          r_age[i] <= '0;
        end else begin
          r_age[i] <= r_age[i] | w_free_grant;
        end
      end
    end
  end
`else
  localparam bit AGE_EN = 1'b0;
  assign w_age_flat = '0;
`endif

  rs_select #(
    .N      (RS_SIZE),
    .IDX_W  (IDX_W),
    .AGE_EN (1'b0)
  ) u_free_sel (
    .i_req   (~r_busy),
    .i_age   ({(RS_SIZE*RS_SIZE){1'b0}}),
    .o_grant (w_free_grant),
    .o_idx   (w_unused_free_idx),
    .o_vld   (w_free_vld)
  );

  rs_select #(
    .N      (RS_SIZE),
    .IDX_W  (IDX_W),
    .AGE_EN (AGE_EN)
  ) u_disp_sel (
    .i_req   (w_ready),
    .i_age   (w_age_flat),
    .o_grant (w_disp_grant),
    .o_idx   (w_disp_idx),
    .o_vld   (w_disp_vld)
  );

  // Control state and dispatch outputs. Flush wins over everything and is
  // honored while stalled; a stall freezes state and suppresses the strobe.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy      <= '0;
      r_qj_busy   <= '0;
      r_qk_busy   <= '0;
      r_new_calc  <= 1'b0;
      r_out_op    <= '0;
      r_out_inst  <= '0;
      r_out_vj    <= '0;
      r_out_vk    <= '0;
      r_out_pc    <= '0;
      r_out_imm   <= '0;
      r_out_entry <= '0;
    end else if (clear_in) begin
      r_busy     <= '0;
      r_new_calc <= 1'b0;
    end else if (rdy_in) begin
      r_new_calc <= w_disp_vld;
      if (w_disp_vld) begin
        r_out_op    <= r_op[w_disp_idx];
        r_out_inst  <= r_inst[w_disp_idx];
        r_out_vj    <= r_vj[w_disp_idx];
        r_out_vk    <= r_vk[w_disp_idx];
        r_out_pc    <= r_pc[w_disp_idx];
        r_out_imm   <= r_imm[w_disp_idx];
        r_out_entry <= r_dest[w_disp_idx];
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_j_alu[i] || w_j_lsb[i]) r_qj_busy[i] <= 1'b0;
        if (w_k_alu[i] || w_k_lsb[i]) r_qk_busy[i] <= 1'b0;
        if (w_disp_grant[i]) r_busy[i] <= 1'b0;
        // The issue slot is free, so it never collides with dispatch/wakeup.
        if (w_issue_go && w_free_grant[i]) begin
          r_busy[i]    <= 1'b1;
          r_qj_busy[i] <= w_iss_qj_busy;
          r_qk_busy[i] <= w_iss_qk_busy;
        end
      end
    end else begin
      r_new_calc <= 1'b0;
    end
  end

  // Payload: operand capture on wakeup and field write on issue.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_j_alu[i]) r_vj[i] <= alu_result;
        else if (w_j_lsb[i]) r_vj[i] <= lsb_result;
        if (w_k_alu[i]) r_vk[i] <= alu_result;
        else if (w_k_lsb[i]) r_vk[i] <= lsb_result;
        if (w_issue_go && w_free_grant[i]) begin
          r_op[i]   <= issue_op;
          r_inst[i] <= issue_instruction;
          r_pc[i]   <= issue_pc;
          r_imm[i]  <= issue_imm;
          r_vj[i]   <= w_iss_vj;
          r_vk[i]   <= w_iss_vk;
          r_qj[i]   <= issue_qj;
          r_qk[i]   <= issue_qk;
          r_dest[i] <= issue_entry;
        end
      end
    end
  end

  assign new_calculate = r_new_calc;
  assign op            = r_out_op;
  assign instruction   = r_out_inst;
  assign vj            = r_out_vj;
  assign vk            = r_out_vk;
  assign pc            = r_out_pc;
  assign imm           = r_out_imm;
  assign entry         = r_out_entry;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_in;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_instruction, issue_pc, issue_imm, issue_vj, issue_vk;
  logic        issue_qj_busy, issue_qk_busy;
  tag_t        issue_qj, issue_qk, issue_entry;
  logic        rs_full;
  logic        alu_broadcast, lsb_broadcast;
  logic [31:0] alu_result, lsb_result;
  tag_t        alu_entry, lsb_entry;
  logic        new_calculate;
  logic [5:0]  op;
  logic [31:0] instruction, vj, vk, pc, imm;
  tag_t        entry;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] vj;
    logic [31:0] vk;
    tag_t        ent;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_rs dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_instruction(issue_instruction),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_entry(issue_entry), .rs_full(rs_full),
    .alu_broadcast(alu_broadcast), .alu_result(alu_result), .alu_entry(alu_entry),
    .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result), .lsb_entry(lsb_entry),
    .new_calculate(new_calculate), .op(op), .instruction(instruction),
    .vj(vj), .vk(vk), .pc(pc), .imm(imm), .entry(entry)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] pc_of(input tag_t e);
    return 32'h0000_1000 + (32'(e) << 2);
  endfunction
  function automatic logic [31:0] imm_of(input tag_t e);
    return 32'h0000_0100 + 32'(e) * 3;
  endfunction
  function automatic logic [31:0] inst_of(input logic [5:0] o, input tag_t e);
    return {8'hA5, 10'd0, o, 3'd0, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [5:0] o, input logic [31:0] j, input logic [31:0] k,
                          input tag_t e);
    exp_t x;
    x.op = o; x.inst = inst_of(o, e); x.pc = pc_of(e); x.imm = imm_of(e);
    x.vj = j; x.vk = k; x.ent = e;
    exp_q.push_back(x);
  endtask

  // Advance one clock and sample #1 later; any dispatch is scored against
  // the head of the expected queue.
  task automatic step();
    exp_t x;
    @(posedge clk_in);
    #1;
    if (new_calculate === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dispatch", 32'(new_calculate), 32'd0);
      end else begin
        x = exp_q.pop_front();
        check("disp_op",    32'(op),    32'(x.op));
        check("disp_inst",  instruction, x.inst);
        check("disp_pc",    pc,          x.pc);
        check("disp_imm",   imm,         x.imm);
        check("disp_vj",    vj,          x.vj);
        check("disp_vk",    vk,          x.vk);
        check("disp_entry", 32'(entry), 32'(x.ent));
      end
    end
  endtask

  task automatic drive_issue(input logic [5:0] o, input logic [31:0] j, input logic [31:0] k,
                             input logic qjb, input tag_t qj, input logic qkb, input tag_t qk,
                             input tag_t e);
    issue_valid = 1'b1; issue_op = o; issue_vj = j; issue_vk = k;
    issue_qj_busy = qjb; issue_qj = qj; issue_qk_busy = qkb; issue_qk = qk;
    issue_entry = e; issue_pc = pc_of(e); issue_imm = imm_of(e);
    issue_instruction = inst_of(o, e);
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; alu_broadcast = 1'b0; lsb_broadcast = 1'b0; clear_in = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_instruction = '0; issue_pc = '0; issue_imm = '0;
    issue_vj = '0; issue_vk = '0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_entry = '0;
    alu_broadcast = 1'b0; alu_result = '0; alu_entry = '0;
    lsb_broadcast = 1'b0; lsb_result = '0; lsb_entry = '0;

    // Reset values
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_new_calc", 32'(new_calculate), 32'd0);
    check("rst_full",     32'(rs_full),       32'd0);
    check("rst_op",       32'(op),            32'd0);
    check("rst_vj",       vj,                 32'd0);
    check("rst_entry",    32'(entry),         32'd0);
    rst_n_in = 1'b1;
    step();

    // Basic ADD, both operands ready: dispatch one cycle after issue, 1 cycle wide
    drive_issue(OP_ADD, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    push_exp(OP_ADD, 32'd5, 32'd7, 5'd3);
    step();
    idle_inputs();
    check("add_not_same_cycle", 32'(new_calculate), 32'd0);
    step();
    check("add_dispatch", 32'(new_calculate), 32'd1);
    step();
    check("add_one_cycle", 32'(new_calculate), 32'd0);

    // Wakeup through ALU port two cycles after issue
    drive_issue(OP_SUB, 32'd0, 32'd2, 1'b1, 5'd9, 1'b0, 5'd0, 5'd5);
    step();
    idle_inputs();
    step();
    check("wait_no_disp", 32'(new_calculate), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 5'd9; alu_result = 32'h0000_1234;
    push_exp(OP_SUB, 32'h0000_1234, 32'd2, 5'd5);
    step();
    idle_inputs();
    check("wake_not_same_cycle", 32'(new_calculate), 32'd0);
    step();
    check("wake_dispatch", 32'(new_calculate), 32'd1);

    // Issue bypass from LSB port on qk
    drive_issue(OP_XOR, 32'd11, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd6);
    lsb_broadcast = 1'b1; lsb_entry = 5'd4; lsb_result = 32'h0000_ABCD;
    push_exp(OP_XOR, 32'd11, 32'h0000_ABCD, 5'd6);
    step();
    idle_inputs();
    step();
    check("bypass_dispatch", 32'(new_calculate), 32'd1);

    // Both operands wake in the same cycle from different ports
    drive_issue(OP_AND, 32'd0, 32'd0, 1'b1, 5'd6, 1'b1, 5'd7, 5'd8);
    step();
    idle_inputs();
    alu_broadcast = 1'b1; alu_entry = 5'd6; alu_result = 32'hDEAD_0006;
    lsb_broadcast = 1'b1; lsb_entry = 5'd7; lsb_result = 32'hBEEF_0007;
    push_exp(OP_AND, 32'hDEAD_0006, 32'hBEEF_0007, 5'd8);
    step();
    idle_inputs();
    step();
    check("jk_wake_dispatch", 32'(new_calculate), 32'd1);

    // Dispatch and issue into a different slot in the same cycle
    drive_issue(OP_OR, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd10);
    push_exp(OP_OR, 32'd1, 32'd2, 5'd10);
    step();
    drive_issue(OP_SLL, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 5'd0, 5'd11);
    push_exp(OP_SLL, 32'd3, 32'd4, 5'd11);
    step();
    idle_inputs();
    step();
    check("overlap_second_disp", 32'(new_calculate), 32'd1);
    step();

    // Fill all 16 slots waiting on tag 1, reject a 17th, then drain in order
    for (int i = 0; i < 16; i++) begin
      drive_issue(OP_ADD, 32'd0, 32'(i), 1'b1, 5'd1, 1'b0, 5'd0, 5'(i));
      step();
    end
    idle_inputs();
    check("full_set", 32'(rs_full), 32'd1);
    drive_issue(OP_BEQ, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 5'd0, 5'd20);
    step();
    idle_inputs();
    check("full_hold", 32'(rs_full), 32'd1);
    check("full_no_disp", 32'(new_calculate), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 5'd1; alu_result = 32'h0000_1111;
    for (int i = 0; i < 16; i++) push_exp(OP_ADD, 32'h0000_1111, 32'(i), 5'(i));
    step();
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      step();
      check("drain_strobe", 32'(new_calculate), 32'd1);
    end
    step();
    check("drain_done", 32'(new_calculate), 32'd0);
    check("drain_not_full", 32'(rs_full), 32'd0);

    // Flush with 5 waiting entries plus a concurrent ready issue
    for (int i = 0; i < 5; i++) begin
      drive_issue(OP_SRL, 32'd0, 32'd0, 1'b1, 5'd2, 1'b1, 5'd2, 5'(12 + i));
      step();
    end
    idle_inputs();
    drive_issue(OP_BNE, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd30);
    clear_in = 1'b1;
    step();
    idle_inputs();
    check("flush_not_full", 32'(rs_full), 32'd0);
    check("flush_no_disp", 32'(new_calculate), 32'd0);
    alu_broadcast = 1'b1; alu_entry = 5'd2; alu_result = 32'h2222_2222;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_silent", 32'(new_calculate), 32'd0);
    end

    // Stall: ready entry held for 3 cycles, dispatches once after release
    drive_issue(OP_ADD, 32'h10, 32'h20, 1'b0, 5'd0, 1'b0, 5'd0, 5'd12);
    push_exp(OP_ADD, 32'h10, 32'h20, 5'd12);
    step();
    idle_inputs();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_disp", 32'(new_calculate), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    check("stall_release_disp", 32'(new_calculate), 32'd1);
    step();
    check("stall_once", 32'(new_calculate), 32'd0);

    // Asynchronous reset mid-operation drops a ready entry and clears outputs
    drive_issue(OP_ADD, 32'h55, 32'h66, 1'b0, 5'd0, 1'b0, 5'd0, 5'd13);
    step();
    idle_inputs();
    #2;
    rst_n_in = 1'b0;
    #1;
    check("async_rst_vj", vj, 32'd0);
    check("async_rst_new_calc", 32'(new_calculate), 32'd0);
    step();
    rst_n_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_rst_silent", 32'(new_calculate), 32'd0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
